w_and_x_loader: RTL and testbench

Assembles weight and activation vectors from a stream of single `data_size`-bit words and drives packed `w` and `x` buses toward the w/x spreader. Each vector is `size` words; a completed weight vector is committed with a one-cycle `set_w` pulse. A completed activation vector is committed with an `x_valid`/`x_ready` handshake. The block is the producer side of the spreader's `w`, `x` and `set_w` inputs and sits between the host/memory word stream and the array datapath.

---
 rtl/w_and_x_loader_if.sv | 26 ++
 rtl/w_and_x_loader.sv | 106 ++++++++++
 tb/tb_w_and_x_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/w_and_x_loader_if.sv
// Word stream in, committed w/x vectors out, between host stream and the w/x spreader.
// slave is the loader side, master is the host/consumer side.
interface w_and_x_loader_if #(
    parameter int unsigned size      = 3,
    parameter int unsigned data_size = 16
);
    logic [data_size-1:0]      in_data;
    logic                      in_valid;
    logic                      in_is_w;
    logic                      in_ready;
    logic [data_size*size-1:0] w;
    logic [data_size*size-1:0] x;
    logic                      set_w;
    logic                      x_valid;
    logic                      x_ready;

    modport slave (
        input  in_data, in_valid, in_is_w, x_ready,
        output in_ready, w, x, set_w, x_valid
    );

    modport master (
        output in_data, in_valid, in_is_w, x_ready,
        input  in_ready, w, x, set_w, x_valid
    );
endinterface

// File: rtl/w_and_x_loader.sv
// Assembles size-word weight/activation vectors and commits them whole to w (set_w pulse)
// or x (x_valid/x_ready handshake).
module w_and_x_loader #(
    parameter int unsigned size      = 3,
    parameter int unsigned data_size = 16
) (
    input logic                clk,
    input logic                reset,
    w_and_x_loader_if.slave    bus
);
    localparam int unsigned IdxW = (size > 1) ? $clog2(size) : 1;
    localparam int unsigned BusW = data_size * size;

    typedef enum logic [1:0] {
        StLoad   = 2'd0,
        StPulseW = 2'd1,
        StHoldX  = 2'd2
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [IdxW-1:0] r_idx, w_idx_nxt;
    logic            r_typ, w_typ_nxt;
    logic [BusW-1:0] r_buf, w_buf_nxt;
    logic [BusW-1:0] r_w, w_w_nxt;
    logic [BusW-1:0] r_x, w_x_nxt;

    logic            w_in_ready;
    logic            w_fire;
    logic            w_last;
    logic            w_typ_cur;
    logic [BusW-1:0] w_buf_wr;

    // Reset gates in_ready so no word is taken while reset is held.
    assign w_in_ready = (r_state == StLoad) && !reset;
    assign w_fire     = bus.in_valid && w_in_ready;
    assign w_last     = (r_idx == IdxW'(size - 1));
    // On lane 0 the type is the incoming flag (matters when size is 1).
    assign w_typ_cur  = (r_idx == '0) ? bus.in_is_w : r_typ;

    always_comb begin
        w_buf_wr = r_buf;
        w_buf_wr[data_size*r_idx +: data_size] = bus.in_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_typ_nxt   = r_typ;
        w_buf_nxt   = r_buf;
        w_w_nxt     = r_w;
        w_x_nxt     = r_x;
        case (r_state)
            StLoad: begin
                if (w_fire) begin
                    w_buf_nxt = w_buf_wr;
                    if (r_idx == '0) begin
                        w_typ_nxt = bus.in_is_w;
                    end
                    if (w_last) begin
                        w_idx_nxt = '0;
                        if (w_typ_cur) begin
                            w_w_nxt     = w_buf_wr;
                            w_state_nxt = StPulseW;
                        end else begin
                            w_x_nxt     = w_buf_wr;
                            w_state_nxt = StHoldX;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            StPulseW: w_state_nxt = StLoad;
            StHoldX: begin
                if (bus.x_ready) begin
                    w_state_nxt = StLoad;
                end
            end
            default: w_state_nxt = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StLoad;
            r_idx   <= '0;
            r_typ   <= 1'b0;
            r_buf   <= '0;
            r_w     <= '0;
            r_x     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_typ   <= w_typ_nxt;
            r_buf   <= w_buf_nxt;
            r_w     <= w_w_nxt;
            r_x     <= w_x_nxt;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.w        = r_w;
    assign bus.x        = r_x;
    assign bus.set_w    = (r_state == StPulseW);
    assign bus.x_valid  = (r_state == StHoldX);
endmodule

// File: tb/tb_w_and_x_loader.sv
// Randomized self-checking bench for w_and_x_loader with a vector-level reference model.
module tb_w_and_x_loader;
    localparam int unsigned Size  = 3;
    localparam int unsigned DataW = 16;
    localparam int unsigned BusW  = Size * DataW;

    logic clk;
    logic reset;

    w_and_x_loader_if #(.size(Size), .data_size(DataW)) bus_if ();

    w_and_x_loader #(.size(Size), .data_size(DataW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [BusW-1:0] exp_w = '0;
    logic [BusW-1:0] exp_x = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Invariants watched every cycle outside reset.
    logic            rst_edge;
    logic            prev_set_w;
    logic            prev_xv;
    logic [BusW-1:0] prev_w;
    logic [BusW-1:0] prev_x;

    always @(posedge clk) rst_edge <= reset;

    always @(negedge clk) begin
        if (!rst_edge) begin
            check("overlap", {63'd0, bus_if.set_w && bus_if.x_valid}, 64'd0);
            if (prev_set_w) check("set_w_double", {63'd0, bus_if.set_w}, 64'd0);
            if (bus_if.w !== prev_w) check("w_change_no_set_w", {63'd0, bus_if.set_w}, 64'd1);
            if (bus_if.x !== prev_x)
                check("x_change_no_commit", {63'd0, bus_if.x_valid && !prev_xv}, 64'd1);
        end
        prev_set_w = bus_if.set_w;
        prev_xv    = bus_if.x_valid;
        prev_w     = bus_if.w;
        prev_x     = bus_if.x;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DataW-1:0] d, input logic t);
        int n = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        bus_if.in_is_w  = t;
        while (!bus_if.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 64'd0, 64'd1);
        tick();
        bus_if.in_valid = 1'b0;
    endtask

    // Sends one vector; returns in the cycle after the last-lane transfer and checks the commit.
    task automatic send_vec(input logic [BusW-1:0] v, input logic typ, input bit gaps,
                            input bit flip);
        logic t;
        for (int i = 0; i < Size; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) tick();
            if (i == 0) t = typ;
            else if (flip) t = ~typ;
            else t = 1'($urandom_range(0, 1));
            send_word(v[DataW*i +: DataW], t);
        end
        if (typ) exp_w = v;
        else exp_x = v;
        check("commit_set_w", {63'd0, bus_if.set_w}, {63'd0, typ});
        check("commit_x_valid", {63'd0, bus_if.x_valid}, {63'd0, !typ});
        check("commit_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
        check("commit_w", 64'(bus_if.w), 64'(exp_w));
        check("commit_x", 64'(bus_if.x), 64'(exp_x));
    endtask

    task automatic after_w();
        tick();
        check("set_w_drop", {63'd0, bus_if.set_w}, 64'd0);
        check("in_ready_after_w", {63'd0, bus_if.in_ready}, 64'd1);
    endtask

    // Holds x_ready low for hold_n further cycles, then consumes x.
    task automatic consume_x(input int hold_n);
        for (int k = 0; k < hold_n; k++) begin
            tick();
            check("hold_x_valid", {63'd0, bus_if.x_valid}, 64'd1);
            check("hold_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
            check("hold_x", 64'(bus_if.x), 64'(exp_x));
        end
        bus_if.x_ready = 1'b1;
        tick();
        bus_if.x_ready = 1'b0;
        check("x_valid_drop", {63'd0, bus_if.x_valid}, 64'd0);
        check("in_ready_after_x", {63'd0, bus_if.in_ready}, 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_w", 64'(bus_if.w), 64'd0);
        check("rst_x", 64'(bus_if.x), 64'd0);
        check("rst_x_valid", {63'd0, bus_if.x_valid}, 64'd0);
        check("rst_set_w", {63'd0, bus_if.set_w}, 64'd0);
        check("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
        reset = 1'b0;
        exp_w = '0;
        exp_x = '0;
        #1;
        check("in_ready_after_rst", {63'd0, bus_if.in_ready}, 64'd1);
    endtask

    logic [BusW-1:0] v;
    logic            typ;

    initial begin
        reset           = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 16'h5A5A;
        bus_if.in_is_w  = 1'b1;
        bus_if.x_ready  = 1'b0;

        // Reset with in_valid high: nothing may be accepted.
        tick();
        check("rst_in_ready_c1", {63'd0, bus_if.in_ready}, 64'd0);
        bus_if.in_valid = 1'b1;
        do_reset();
        bus_if.in_valid = 1'b0;

        send_vec(48'h0003_0002_0001, 1'b1, 1'b0, 1'b0);
        after_w();

        bus_if.x_ready = 1'b0;
        send_vec(48'hCCCC_BBBB_AAAA, 1'b0, 1'b0, 1'b0);
        consume_x(4);

        // Type follows lane 0 even when lanes 1..2 carry the opposite flag.
        send_vec(48'h1357_2468_9ABC, 1'b1, 1'b1, 1'b1);
        after_w();
        send_vec(48'hDEAD_BEEF_F00D, 1'b0, 1'b1, 1'b1);
        consume_x(0);

        // Abort after two words; only post-reset words may appear.
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        do_reset();
        send_vec(48'h6666_5555_4444, 1'b0, 1'b0, 1'b0);
        consume_x(1);

        // Reset while x is pending drops x_valid without consumption.
        send_vec(48'h7777_8888_9999, 1'b0, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 20; i++) begin
            v   = {16'($urandom), 16'($urandom), 16'($urandom)};
            typ = 1'(i % 2 == 0);
            bus_if.x_ready = typ ? 1'($urandom_range(0, 1)) : 1'b0;
            send_vec(v, typ, 1'($urandom_range(0, 1)), 1'b0);
            bus_if.x_ready = 1'b0;
            if (typ) after_w();
            else consume_x(int'($urandom_range(0, 3)));
        end

        tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
